csa_reduction_pipe: RTL and testbench
=====================================

Name: csa_reduction_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree for the multiplier partial-product array.
- Takes NUM_OPS partial-product words per transaction and reduces them with levels of 3:2 full-adder compressors to a redundant Sum/Carry pair, which goes to the final carry-propagate adder.
- Each reduction level is followed by a pipeline register.
- Valid/ready handshake with per-stage bubble collapsing, so the block stalls cleanly behind a busy final adder.

Parameters:
- WIDTH, 24, bit width of each input operand (partial product).
- NUM_OPS, 21, number of operands per transaction; legal range 3..64.
- SIGNED, 0, 1 = sign-extend operands to OUT_W; 0 = zero-extend.
- OUT_W, WIDTH+$clog2(NUM_OPS), width of the Sum and Carry outputs; all arithmetic is modulo 2^OUT_W.

Ports:
- Clk  input  1  rising-edge clock
- RstN  input  1  asynchronous active-low reset
- InValid  input  1  Operands valid this cycle
- InReady  output  1  block accepts Operands this cycle
- Operands  input  NUM_OPS*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH]
- OutValid  output  1  Sum/Carry valid
- OutReady  input  1  downstream accepts Sum/Carry
- Sum  output  OUT_W  redundant sum vector
- Carry  output  OUT_W  redundant carry vector, already weighted (shifted)

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (RstN).
- Level schedule:
  - n0 = NUM_OPS; n(j+1) = 2*floor(nj/3) + (nj mod 3).
  - Repeat until n = 2. L = number of levels, computed at elaboration.
  - NUM_OPS=21 gives 21,14,10,7,5,4,3,2, so L=7. NUM_OPS=3 gives L=1.
- Per level:
  - Words are grouped in index order: words 3i, 3i+1, 3i+2 feed full-adder bank i.
  - Bank i produces s_i = a^b^c and c_i = maj(a,b,c)<<1, truncated to OUT_W.
  - Outputs are ordered s_0, c_0, s_1, c_1, …, followed by the leftover (nj mod 3) words passed through unchanged.
  - Final stage: word 0 drives Sum, word 1 drives Carry.
- Extension: each operand is extended to OUT_W at entry, using sign extension if SIGNED else zero extension.
- Invariant: (Sum + Carry) mod 2^OUT_W = (Σ extended operands) mod 2^OUT_W.
- Pipeline:
  - One register stage per level, each with its own valid bit v[j].
  - The level-L register drives Sum, Carry and OutValid.
  - Latency L cycles from acceptance to OutValid when there is no stall.
  - Throughput is 1 transaction/cycle.
- Handshake:
  - Stage j loads when ready[j] = !v[j] || ready[j+1]; ready[L+1] = OutReady.
  - InReady = ready[1], combinational, with no dependence on InValid.
  - Acceptance occurs on InValid && InReady; otherwise stage 1's valid bit loads 0 when ready.
  - A stage that does not load holds its data and valid bit unchanged.
  - Output handshake completes on OutValid && OutReady.
  - Sum and Carry stay stable while OutValid=1 and OutReady=0.
- Bubbles: an empty stage accepts even when downstream is stalled. Up to L transactions can be held in flight under a full stall.
- Simultaneous accept and emit while full and OutReady=1: all stages shift and nothing is lost or duplicated.
- Reset:
  - Asynchronous assertion clears all v[j] and all data registers to 0.
  - Outputs during reset: OutValid=0, Sum=0, Carry=0, InReady=1 (from first clock edge after deassertion and combinationally during reset).
  - In-flight transactions are discarded, with no partial output.
- Non-valid stage data is don't-care but must not corrupt valid stages.
- Elaboration: NUM_OPS < 3 is a parameter error.

Test Plan:
- Defaults, all 21 operands = 24'hFFFFFF, OutReady=1, single transaction:
  - OutValid rises exactly 7 cycles after acceptance.
  - Sum+Carry mod 2^29 = 21*16777215 = 352321515.
- SIGNED=1, WIDTH=8, NUM_OPS=3, operands 8'h80, 8'h80, 8'h01:
  - L=1.
  - Sum+Carry mod 2^10 = 10'h301 (-255).
- Stall, defaults:
  - Stream 10 back-to-back random transactions with OutReady=0.
  - InReady drops after exactly 7 accepts.
  - Release OutReady: 10 results emerge in order, each matching the reference sum, with no gaps once streaming.
- Bubble collapse:
  - Accept transaction A, idle 3 cycles, accept B, with OutReady held 0 throughout.
  - Both A and B are held.
  - OutValid with A's result, then B's result on the following cycle after OutReady=1.
- Reset mid-operation:
  - Assert RstN=0 asynchronously with 5 transactions in flight.
  - OutValid=0, Sum=Carry=0 immediately (before the next Clk edge).
  - After release, no stale results emerge; the next accepted transaction returns correctly after 7 cycles.
- Randomised sweep over NUM_OPS ∈ {3,4,5,21,64}, WIDTH ∈ {4,24,53}, random OutReady backpressure:
  - Scoreboard checks the Sum+Carry invariant and in-order delivery for 10k transactions.

Source files
------------

// File: rtl/csa_reduction_pipe_if.sv
// Handshake bundle for csa_reduction_pipe: operand words in, redundant Sum/Carry pair out.
// The master side feeds operands and absorbs results; the slave side is the reduction pipe.
interface csa_reduction_pipe_if #(
  parameter int WIDTH   = 24,
  parameter int NUM_OPS = 21,
  parameter int OUT_W   = WIDTH + $clog2(NUM_OPS)
) ();

  logic                     InValid;
  logic                     InReady;
  logic [NUM_OPS*WIDTH-1:0] Operands;
  logic                     OutValid;
  logic                     OutReady;
  logic [OUT_W-1:0]         Sum;
  logic [OUT_W-1:0]         Carry;

  modport master (
    output InValid, Operands, OutReady,
    input  InReady, OutValid, Sum, Carry
  );

  modport slave (
    input  InValid, Operands, OutReady,
    output InReady, OutValid, Sum, Carry
  );

endinterface

// File: rtl/csa_reduction_pipe.sv
// Pipelined 3:2 carry-save reduction tree: NUM_OPS partial products down to a Sum/Carry pair,
// one register per level, valid/ready flow control with bubble collapsing.
module csa_reduction_pipe #(
  parameter int WIDTH   = 24,
  parameter int NUM_OPS = 21,
  parameter bit SIGNED  = 1'b0,
  parameter int OUT_W   = WIDTH + $clog2(NUM_OPS)
) (
  input logic                  Clk,
  input logic                  RstN,
  csa_reduction_pipe_if.slave  bus
);

  function automatic int nextCount(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Number of words entering level lvl (level 0 sees the raw operands).
  function automatic int levelCount(input int lvl);
    int n;
    n = NUM_OPS;
    for (int j = 0; j < lvl; j++) n = nextCount(n);
    return n;
  endfunction

  function automatic int countLevels();
    int n;
    int l;
    n = NUM_OPS;
    l = 0;
    while (n > 2) begin
      n = nextCount(n);
      l++;
    end
    return l;
  endfunction

  // Offset of level lvl's register words inside the flat stageQ array.
  function automatic int qBase(input int lvl);
    int s;
    s = 0;
    for (int m = 1; m <= lvl; m++) s += levelCount(m);
    return s;
  endfunction

  localparam int L      = countLevels();
  localparam int QTOTAL = qBase(L);

  if (NUM_OPS < 3 || NUM_OPS > 64) begin : g_param_check
    $error("csa_reduction_pipe: NUM_OPS must lie in 3..64");
  end

  logic [NUM_OPS-1:0][OUT_W-1:0] extOps;
  logic [QTOTAL-1:0][OUT_W-1:0]  stageQ;
  logic [L-1:0]                  stageValid;
  logic [L-1:0]                  stageReady;
  logic [L-1:0]                  validIn;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
    if (SIGNED) begin : g_sext
      assign extOps[k] = OUT_W'($signed(bus.Operands[k*WIDTH +: WIDTH]));
    end else begin : g_zext
      assign extOps[k] = OUT_W'(bus.Operands[k*WIDTH +: WIDTH]);
    end
  end

  // A stage may load if it is empty or anything between it and the output is empty or draining;
  // expressed without a ready->ready chain so there is no combinational loop through one vector.
  for (genvar j = 0; j < L; j++) begin : g_ready
    assign stageReady[j] = bus.OutReady || !(&stageValid[L-1:j]);
  end

  assign validIn     = L'({stageValid, bus.InValid});
  assign bus.InReady = stageReady[0];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge
  // value of its neighbour and the whole pipe shifts in lockstep.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stageValid <= '0;
    end else begin
      for (int j = 0; j < L; j++) begin
        if (stageReady[j]) stageValid[j] <= validIn[j];
      end
    end
  end

  for (genvar j = 0; j < L; j++) begin : g_level
    localparam int NIN   = levelCount(j);
    localparam int NOUT  = levelCount(j + 1);
    localparam int NFA   = NIN / 3;
    localparam int NPASS = NIN % 3;

    logic [NIN-1:0][OUT_W-1:0]  din;
    logic [NOUT-1:0][OUT_W-1:0] dnext;
    logic [NOUT-1:0][OUT_W-1:0] q;

    if (j == 0) begin : g_src
      assign din = extOps;
    end else begin : g_src
      assign din = stageQ[qBase(j-1) +: NIN];
    end

    for (genvar i = 0; i < NFA; i++) begin : g_fa
      logic [OUT_W-1:0] a, b, c;
      assign a = din[3*i];
      assign b = din[3*i+1];
      assign c = din[3*i+2];
      assign dnext[2*i]   = a ^ b ^ c;
      // Carry weight is one bit higher; the top bit falls off because arithmetic is mod 2^OUT_W.
      assign dnext[2*i+1] = ((a & b) | (a & c) | (b & c)) << 1;
    end

    for (genvar p = 0; p < NPASS; p++) begin : g_pass
      assign dnext[2*NFA+p] = din[3*NFA+p];
    end

    // NOTE: data registers are reset as well as the valid bits, because Sum and Carry must read
    // zero while reset is held; elsewhere data under a clear valid bit is simply don't-care.
    always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
        q <= '0;
      end else if (stageReady[j]) begin
        q <= dnext;
      end
    end

    assign stageQ[qBase(j) +: NOUT] = q;
  end

  assign bus.OutValid = stageValid[L-1];
  assign bus.Sum      = stageQ[qBase(L-1)];
  assign bus.Carry    = stageQ[qBase(L-1) + 1];

endmodule

// File: tb/tb_csa_reduction_pipe.sv
// Self-checking bench for csa_reduction_pipe: directed latency/stall/bubble/reset scenarios on the
// default build, plus concurrent randomized sweeps scored against a plain-arithmetic sum model.
module tb_csa_reduction_pipe;

  localparam int W      = 24;
  localparam int N      = 21;
  localparam int OW     = 29;
  localparam int NTX    = 2000;
  localparam int NSWEEP = 5;

  logic Clk = 1'b0;
  logic RstN;
  logic sweepRstN;
  always #5 Clk = ~Clk;

  int cycle = 0;
  always @(posedge Clk) cycle++;

  int checks = 0;
  int errors = 0;
  int acceptCnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: extend every operand to 64 bits, add them up, reduce mod 2^ow.
  function automatic logic [63:0] refSum(input logic [4095:0] ops, input int n, input int w,
                                         input bit sgn, input int ow);
    logic [63:0] acc, v, m;
    acc = '0;
    m   = (64'd1 << w) - 64'd1;
    for (int k = 0; k < n; k++) begin
      v = 64'(ops >> (k * w)) & m;
      if (sgn && v[w-1]) v = v | ~m;
      acc = acc + v;
    end
    return acc & ((64'd1 << ow) - 64'd1);
  endfunction

  function automatic logic [4095:0] randOps();
    logic [4095:0] r;
    for (int i = 0; i < 128; i++) r[i*32 +: 32] = $urandom();
    case ($urandom_range(0, 15))
      0:       r = '1;
      1:       r = '0;
      default: ;
    endcase
    return r;
  endfunction

  function automatic int cfgW(input int k);
    case (k)
      0: return 4;
      1: return 24;
      2: return 53;
      3: return 24;
      default: return 53;
    endcase
  endfunction

  function automatic int cfgN(input int k);
    case (k)
      0: return 3;
      1: return 4;
      2: return 5;
      3: return 21;
      default: return 64;
    endcase
  endfunction

  function automatic bit cfgS(input int k);
    return (k == 0 || k == 2 || k == 4);
  endfunction

  // ---------------- default build, directed scenarios ----------------
  csa_reduction_pipe_if #(.WIDTH(W), .NUM_OPS(N), .OUT_W(OW)) dbus ();
  csa_reduction_pipe #(.WIDTH(W), .NUM_OPS(N), .SIGNED(1'b0), .OUT_W(OW)) u_dut (
    .Clk(Clk), .RstN(RstN), .bus(dbus)
  );

  csa_reduction_pipe_if #(.WIDTH(8), .NUM_OPS(3), .OUT_W(10)) sbus ();
  csa_reduction_pipe #(.WIDTH(8), .NUM_OPS(3), .SIGNED(1'b1), .OUT_W(10)) u_sgn (
    .Clk(Clk), .RstN(RstN), .bus(sbus)
  );

  logic [63:0]   mq[$];
  bit            mPrevStall = 1'b0;
  logic [OW-1:0] mPrevSum, mPrevCarry;

  always @(negedge Clk) begin
    if (!RstN) begin
      mPrevStall = 1'b0;
    end else begin
      if (mPrevStall) begin
        check("main_hold_valid", 64'(dbus.OutValid), 64'd1);
        check("main_hold_sum", 64'(dbus.Sum), 64'(mPrevSum));
        check("main_hold_carry", 64'(dbus.Carry), 64'(mPrevCarry));
      end
      if (dbus.OutValid && dbus.OutReady) begin
        if (mq.size() == 0) fail("main_unexpected_output");
        else check("main_sum_carry", 64'(OW'(dbus.Sum + dbus.Carry)), mq.pop_front());
      end
      mPrevStall = dbus.OutValid && !dbus.OutReady;
      mPrevSum   = dbus.Sum;
      mPrevCarry = dbus.Carry;
    end
  end

  task automatic sendOne(input logic [N*W-1:0] ops, input logic [63:0] exp, output int accCycle);
    int budget;
    budget = 0;
    dbus.InValid  = 1'b1;
    dbus.Operands = ops;
    do begin
      @(negedge Clk);
      budget++;
    end while (!dbus.InReady && budget < 100);
    if (!dbus.InReady) begin
      fail("send_timeout");
    end else begin
      mq.push_back(exp);
      acceptCnt++;
    end
    accCycle = cycle;
    @(posedge Clk); #1;
    dbus.InValid = 1'b0;
  endtask

  task automatic waitOut(input int accCycle, input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!dbus.OutValid && n < 40);
    if (!dbus.OutValid) fail({name, "_timeout"});
    else check(name, 64'(cycle - accCycle), 64'(lat));
  endtask

  // ---------------- randomized sweeps ----------------
  wire [NSWEEP-1:0] sweepDone;

  for (genvar k = 0; k < NSWEEP; k++) begin : g_sweep
    localparam int SW = cfgW(k);
    localparam int SN = cfgN(k);
    localparam bit SS = cfgS(k);
    localparam int SO = SW + $clog2(SN);

    csa_reduction_pipe_if #(.WIDTH(SW), .NUM_OPS(SN), .OUT_W(SO)) bus ();
    csa_reduction_pipe #(.WIDTH(SW), .NUM_OPS(SN), .SIGNED(SS), .OUT_W(SO)) u_dut (
      .Clk(Clk), .RstN(sweepRstN), .bus(bus)
    );

    logic [63:0]   q[$];
    int            sent = 0;
    int            got  = 0;
    bit            done = 1'b0;
    bit            prevStall = 1'b0;
    logic [SO-1:0] prevSum, prevCarry;

    assign sweepDone[k] = done;

    initial begin : drive
      logic [4095:0] ops;
      logic [63:0]   exp;
      bit            acceptedLast;
      acceptedLast  = 1'b0;
      bus.InValid   = 1'b0;
      bus.Operands  = '0;
      wait (sweepRstN === 1'b1);
      while (sent < NTX) begin
        @(posedge Clk); #1;
        if (acceptedLast) bus.InValid = 1'b0;
        acceptedLast = 1'b0;
        if (!bus.InValid && $urandom_range(0, 9) < 7) begin
          ops          = randOps();
          bus.Operands = ops[SN*SW-1:0];
          exp          = refSum(ops, SN, SW, SS, SO);
          bus.InValid  = 1'b1;
        end
        @(negedge Clk);
        if (bus.InValid && bus.InReady) begin
          q.push_back(exp);
          sent++;
          acceptedLast = 1'b1;
        end
      end
      @(posedge Clk); #1;
      bus.InValid = 1'b0;
    end

    initial begin : backpressure
      int pct;
      pct = 100;
      bus.OutReady = 1'b0;
      forever begin
        @(posedge Clk); #1;
        if ($urandom_range(0, 199) == 0) begin
          case ($urandom_range(0, 3))
            0:       pct = 5;
            1:       pct = 30;
            2:       pct = 70;
            default: pct = 100;
          endcase
        end
        bus.OutReady = ($urandom_range(0, 99) < pct);
      end
    end

    always @(negedge Clk) begin
      if (sweepRstN) begin
        if (prevStall) begin
          check($sformatf("sweep%0d_hold_sum", k), 64'(bus.Sum), 64'(prevSum));
          check($sformatf("sweep%0d_hold_carry", k), 64'(bus.Carry), 64'(prevCarry));
        end
        if (bus.OutValid && bus.OutReady) begin
          if (q.size() == 0) begin
            fail($sformatf("sweep%0d_unexpected_output", k));
          end else begin
            check($sformatf("sweep%0d_sum_carry", k), 64'(SO'(bus.Sum + bus.Carry)), q.pop_front());
            got++;
            if (got == NTX) done = 1'b1;
          end
        end
        prevStall = bus.OutValid && !bus.OutReady;
        prevSum   = bus.Sum;
        prevCarry = bus.Carry;
      end
    end
  end

  // ---------------- directed sequence ----------------
  logic [4095:0] ops;
  int acc, n, gaps, stale, base;

  initial begin
    RstN          = 1'b1;
    sweepRstN     = 1'b1;
    dbus.InValid  = 1'b0;
    dbus.Operands = '0;
    dbus.OutReady = 1'b1;
    sbus.InValid  = 1'b0;
    sbus.Operands = '0;
    sbus.OutReady = 1'b1;
    #1;
    RstN      = 1'b0;
    sweepRstN = 1'b0;
    #2;
    check("rst_inready", 64'(dbus.InReady), 64'd1);
    check("rst_outvalid", 64'(dbus.OutValid), 64'd0);
    check("rst_sum", 64'(dbus.Sum), 64'd0);
    check("rst_carry", 64'(dbus.Carry), 64'd0);
    repeat (2) @(posedge Clk);
    #3;
    RstN      = 1'b1;
    sweepRstN = 1'b1;
    @(posedge Clk); #1;

    // All operands at full scale, no stall.
    ops = '1;
    sendOne(ops[N*W-1:0], 64'd352321515, acc);
    waitOut(acc, 7, "allones_latency");
    @(posedge Clk); #1;

    // Signed, three 8-bit operands: -128 + -128 + 1.
    sbus.Operands = {8'h01, 8'h80, 8'h80};
    sbus.InValid  = 1'b1;
    @(negedge Clk);
    check("sgn_inready", 64'(sbus.InReady), 64'd1);
    acc = cycle;
    @(posedge Clk); #1;
    sbus.InValid = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!sbus.OutValid && n < 20);
    if (!sbus.OutValid) fail("sgn_timeout");
    else begin
      check("sgn_latency", 64'(cycle - acc), 64'd1);
      check("sgn_sum_carry", 64'(10'(sbus.Sum + sbus.Carry)), 64'h301);
    end
    @(posedge Clk); #1;

    // Full stall: pipe absorbs exactly seven, then drains without gaps.
    dbus.OutReady = 1'b0;
    base = acceptCnt;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ops = randOps();
          sendOne(ops[N*W-1:0], refSum(ops, N, W, 1'b0, OW), acc);
        end
      end
      begin
        n = 0;
        do begin
          @(negedge Clk);
          n++;
        end while (dbus.InReady && n < 40);
        check("stall_accepts_before_full", 64'(acceptCnt - base), 64'd7);
        repeat (3) begin
          @(negedge Clk);
          check("stall_inready_low", 64'(dbus.InReady), 64'd0);
        end
        @(posedge Clk); #1;
        dbus.OutReady = 1'b1;
        gaps = 0;
        repeat (10) begin
          @(negedge Clk);
          if (!dbus.OutValid) gaps++;
        end
        check("stall_no_gaps", 64'(gaps), 64'd0);
      end
    join
    @(posedge Clk); #1;
    check("stall_drained", 64'(mq.size()), 64'd0);

    // Bubble collapse: A, three idle cycles, B, all behind a stalled output.
    dbus.OutReady = 1'b0;
    ops = randOps();
    sendOne(ops[N*W-1:0], refSum(ops, N, W, 1'b0, OW), acc);
    repeat (3) begin
      @(posedge Clk); #1;
    end
    ops = randOps();
    sendOne(ops[N*W-1:0], refSum(ops, N, W, 1'b0, OW), acc);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    check("bubble_outvalid_held", 64'(dbus.OutValid), 64'd1);
    check("bubble_inready", 64'(dbus.InReady), 64'd1);
    check("bubble_both_held", 64'(mq.size()), 64'd2);
    @(posedge Clk); #1;
    dbus.OutReady = 1'b1;
    @(negedge Clk);
    check("bubble_out_a", 64'(dbus.OutValid), 64'd1);
    @(negedge Clk);
    check("bubble_out_b", 64'(dbus.OutValid), 64'd1);
    @(negedge Clk);
    check("bubble_then_empty", 64'(dbus.OutValid), 64'd0);
    check("bubble_drained", 64'(mq.size()), 64'd0);
    @(posedge Clk); #1;

    // Asynchronous reset with five transactions in flight.
    dbus.OutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ops = randOps();
      sendOne(ops[N*W-1:0], refSum(ops, N, W, 1'b0, OW), acc);
    end
    @(posedge Clk); #3;
    RstN = 1'b0;
    #1;
    check("midrst_outvalid", 64'(dbus.OutValid), 64'd0);
    check("midrst_sum", 64'(dbus.Sum), 64'd0);
    check("midrst_carry", 64'(dbus.Carry), 64'd0);
    check("midrst_inready", 64'(dbus.InReady), 64'd1);
    mq.delete();
    repeat (2) @(posedge Clk);
    #4;
    RstN = 1'b1;
    @(posedge Clk); #1;
    dbus.OutReady = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge Clk);
      if (dbus.OutValid) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);
    @(posedge Clk); #1;
    ops = randOps();
    sendOne(ops[N*W-1:0], refSum(ops, N, W, 1'b0, OW), acc);
    waitOut(acc, 7, "midrst_recovery_latency");
    @(posedge Clk); #1;
    check("midrst_drained", 64'(mq.size()), 64'd0);

    // Let the randomized sweeps finish.
    n = 0;
    while (!(&sweepDone) && n < 60000) begin
      @(posedge Clk);
      n++;
    end
    check("sweep_complete", 64'(sweepDone), 64'({NSWEEP{1'b1}}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
